dynamic_branch_predictor: RTL



---
 rtl/dynamic_branch_predictor_pkg.sv | 29 ++
 rtl/dynamic_branch_predictor_bht_sat_counter.sv | 21 ++
 rtl/dynamic_branch_predictor.sv | 116 +++++++++++
 3 files changed

// File: rtl/dynamic_branch_predictor_pkg.sv
// rtl/dynamic_branch_predictor_pkg.sv - shared types and constants for the branch predictor
package dynamic_branch_predictor_pkg;

   localparam int BP_ENTRIES = 8;

   typedef enum logic [1:0] {
      STRONG_NOT_TAKEN = 2'b00,
      WEAK_NOT_TAKEN   = 2'b01,
      WEAK_TAKEN       = 2'b10,
      STRONG_TAKEN     = 2'b11
   } state_t;

   typedef struct packed {
      logic [15:0] PC_addr;
      state_t      prediction;
      logic        valid;
   } bht_entry_t;

   typedef struct packed {
      logic [15:0] PC_addr;
      logic [15:0] target;
   } btb_entry_t;

   // Statistics counters stick at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/dynamic_branch_predictor_bht_sat_counter.sv
// rtl/dynamic_branch_predictor_bht_sat_counter.sv - 2-bit saturating counter next-state function
module bht_sat_counter
   import dynamic_branch_predictor_pkg::*;
(
   input  state_t state,
   input  logic   taken,
   output state_t next_state
);

   // Taken moves toward STRONG_TAKEN, not-taken toward STRONG_NOT_TAKEN; end states hold.
   always_comb begin
      next_state = state;
      unique case (state)
         STRONG_NOT_TAKEN: next_state = taken ? WEAK_NOT_TAKEN : STRONG_NOT_TAKEN;
         WEAK_NOT_TAKEN:   next_state = taken ? WEAK_TAKEN     : STRONG_NOT_TAKEN;
         WEAK_TAKEN:       next_state = taken ? STRONG_TAKEN   : WEAK_NOT_TAKEN;
         STRONG_TAKEN:     next_state = taken ? STRONG_TAKEN   : WEAK_TAKEN;
      endcase
   end

endmodule

// File: rtl/dynamic_branch_predictor.sv
// rtl/dynamic_branch_predictor.sv - BHT/BTB fetch predictor with decode-time update and statistics
module dynamic_branch_predictor
   import dynamic_branch_predictor_pkg::*;
#(
   parameter int ENTRIES = BP_ENTRIES
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [15:0] PC_curr,
   output logic        predicted_taken,
   output logic [15:0] predicted_target,
   input  logic [15:0] IF_ID_PC_curr,
   input  logic        IF_ID_predicted_taken,
   input  logic [15:0] IF_ID_predicted_target,
   input  logic        is_branch,
   input  logic        actual_taken,
   input  logic [15:0] actual_target,
   output logic        mispredicted,
   output logic [15:0] hit_count,
   output logic [15:0] mispredict_count
);

   localparam int IDX_W = $clog2(ENTRIES);

   // Flop arrays so every entry is observable each cycle.
   bht_entry_t bht [ENTRIES];
   btb_entry_t btb [ENTRIES];

   logic [IDX_W-1:0] fetch_idx;
   logic [IDX_W-1:0] upd_idx;
   bht_entry_t       fetch_bht;
   btb_entry_t       fetch_btb;
   bht_entry_t       upd_bht;
   logic             fetch_hit;
   logic             upd_hit;
   logic             do_update;
   state_t           upd_next_state;
   bht_entry_t       new_bht;

   assign fetch_idx = PC_curr[IDX_W:1];
   assign upd_idx   = IF_ID_PC_curr[IDX_W:1];
   assign fetch_bht = bht[fetch_idx];
   assign fetch_btb = btb[fetch_idx];
   assign upd_bht   = bht[upd_idx];
   assign do_update = enable && is_branch;

   // Fetch lookup: full-PC tag compare guards against aliased entries.
   always_comb begin
      fetch_hit        = fetch_bht.valid && (fetch_bht.PC_addr == PC_curr);
      predicted_taken  = fetch_hit && fetch_bht.prediction[1];
      predicted_target = '0;
      if (fetch_hit && (fetch_btb.PC_addr == PC_curr)) begin
         predicted_target = fetch_btb.target;
      end
   end

   // Decode-side misprediction: wrong direction, or taken to a different target.
   always_comb begin
      mispredicted = 1'b0;
      if (is_branch) begin
         mispredicted = (IF_ID_predicted_taken != actual_taken) ||
                        (actual_taken && (IF_ID_predicted_target != actual_target));
      end
   end

   bht_sat_counter u_bht_sat_counter (
      .state      (upd_bht.prediction),
      .taken      (actual_taken),
      .next_state (upd_next_state)
   );

   // Replacement BHT entry: train on a tag hit, otherwise allocate weakly toward the outcome.
   always_comb begin
      upd_hit = upd_bht.valid && (upd_bht.PC_addr == IF_ID_PC_curr);
      new_bht = upd_bht;
      if (upd_hit) begin
         new_bht.prediction = upd_next_state;
      end else begin
         new_bht.PC_addr    = IF_ID_PC_curr;
         new_bht.prediction = actual_taken ? WEAK_TAKEN : WEAK_NOT_TAKEN;
         new_bht.valid      = 1'b1;
      end
   end

   // Table write on resolved branches; BTB only learns taken targets.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            bht[i] <= '{PC_addr: 16'h0000, prediction: STRONG_NOT_TAKEN, valid: 1'b0};
            btb[i] <= '{PC_addr: 16'h0000, target: 16'h0000};
         end
      end else if (do_update) begin
         bht[upd_idx] <= new_bht;
         if (actual_taken) begin
            btb[upd_idx] <= '{PC_addr: IF_ID_PC_curr, target: actual_target};
         end
      end
   end

   // Statistics use the pre-update lookup and saturate.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_count        <= '0;
         mispredict_count <= '0;
      end else if (do_update) begin
         if (upd_hit) begin
            hit_count <= sat_inc(hit_count);
         end
         if (mispredicted) begin
            mispredict_count <= sat_inc(mispredict_count);
         end
      end
   end

endmodule
